// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
//  Shared definitions for the RV32I multi-cycle control path:
//  opcode constants, the FSM state enum (encodings are visible on
//  state_dbg, so they are fixed), datapath mux encodings and the
//  packed control word produced by the output decoder.
package rv_ctrl_pkg;

    // Major opcodes (instr[6:0]) understood by the controller
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // result_src
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // alu_src_a
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // alu_op
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec
//  Purely combinational state -> control word table (Moore decode).
//  Ports:
//   state  in   current FSM state
//   rdy    in   memory ready (already gated by the handshake option)
//   zero   in   ALU zero flag, used only for the branch PC update
//   ctrl   out  datapath control word; fields not set for a state are 0
module mc_ctrl_outdec
    import rv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       rdy,
    input  logic       zero,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                // PC+4 is computed in the same cycle the instruction is read
                ctrl.adr_src    = 1'b0;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURES;
                ctrl.ir_write   = rdy;
                ctrl.pc_write   = rdy;
            end
            S_DECODE: begin
                // Speculative branch/jump target oldPC + imm into ALUOut
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src  = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                // ALUOut still holds the target computed in DECODE
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = zero;
            end
            S_JAL: begin
                // PC <- target from ALUOut; ALU forms oldPC+4 as the link value
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            default: ctrl = '0;   // S_TRAP and unused encodings: everything off
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//  Moore FSM sequencing RV32I instructions over 3-5 cycles on a shared
//  memory / ALU / register-file datapath.
//  Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   opcode, zero       instr[6:0] from IR, ALU zero flag
//   mem_ready          memory access completes this cycle
//   pc_write..alu_op   datapath enables and mux selects
//   instr_done         registered pulse, one per retired instruction
//   illegal_instr      registered illegal-opcode flag (sticky when trapping)
//   state_dbg          current state encoding
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE   = 1,
    parameter int SUPPORT_JAL     = 1,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    state_t     state_reg, state_next;
    logic       instr_done_reg, illegal_reg;
    logic       retire_next, illegal_next;
    logic       decode_illegal;
    logic       rdy;
    ctrl_word_t ctrl;

    assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_next     = state_reg;
        retire_next    = 1'b0;
        illegal_next   = 1'b0;
        decode_illegal = 1'b0;
        case (state_reg)
            S_FETCH:    if (rdy) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_ITYPE:          state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL: begin
                        if (SUPPORT_JAL != 0) state_next = S_JAL;
                        else                  decode_illegal = 1'b1;
                    end
                    default:           decode_illegal = 1'b1;
                endcase
                if (decode_illegal) begin
                    illegal_next = 1'b1;
                    state_next   = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
                end
            end
            // opcode[5] is the only bit separating store from load
            S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (rdy) state_next = S_MEMWB;
            S_MEMWB: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            S_MEMWRITE: begin
                if (rdy) begin
                    state_next  = S_FETCH;
                    retire_next = 1'b1;
                end
            end
            S_EXEC_R:   state_next = S_ALUWB;
            S_EXEC_I:   state_next = S_ALUWB;
            S_ALUWB: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            S_BEQ: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_FETCH;
            instr_done_reg <= 1'b0;
            illegal_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            instr_done_reg <= retire_next;
            if (TRAP_ON_ILLEGAL != 0)
                illegal_reg <= illegal_reg | illegal_next;
            else
                illegal_reg <= illegal_next;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state (state_reg),
        .rdy   (rdy),
        .zero  (zero),
        .ctrl  (ctrl)
    );

    // Enables are masked by rst_n directly so an access in flight is
    // dropped the moment reset asserts, not at the next clock edge.
    assign pc_write      = ctrl.pc_write  & rst_n;
    assign ir_write      = ctrl.ir_write  & rst_n;
    assign mem_read      = ctrl.mem_read  & rst_n;
    assign mem_write     = ctrl.mem_write & rst_n;
    assign reg_write     = ctrl.reg_write & rst_n;
    assign adr_src       = ctrl.adr_src;
    assign result_src    = ctrl.result_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign instr_done    = instr_done_reg;
    assign illegal_instr = illegal_reg;
    assign state_dbg     = state_reg;

endmodule
